// File: rtl/pixel_window_pkg.sv
// pixel_window_pkg: definitions shared by the window builder and the edge kernel stage.
// Contents:
//   windowState_t      - frame sequencing states {IDLE, FILL, STREAM, DONE}
//   DefaultImageWidth  - default pixels per row
//   DefaultImageHeight - default rows per frame
//   DefaultPixelBits   - default pixel width (matches the SPI receiver write data)
package pixel_window_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } windowState_t;

  localparam int unsigned DefaultImageWidth  = 160;
  localparam int unsigned DefaultImageHeight = 120;
  localparam int unsigned DefaultPixelBits   = 12;

endpackage

// File: rtl/pixel_window_builder_line_buffer.sv
// line_buffer: one image row of pixel storage.
// Ports:
//   i_clk   - clock for the write port
//   i_we    - write enable
//   i_addr  - shared read/write column address
//   i_wdata - write data
//   o_rdata - combinational read data (returns the old value in the write cycle)
// No reset: every entry is written before it is read within a frame.
module line_buffer #(
  parameter int unsigned Depth = 160,
  parameter int unsigned Width = 12
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_addr,
  input  logic [Width-1:0]         i_wdata,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/pixel_window_builder.sv
// pixel_window_builder: builds 3x3 neighbourhoods from a raster pixel strobe stream.
// Ports:
//   i_clk, i_reset        - clock, asynchronous active-high reset
//   i_pixel_data/_valid   - pixel and one-cycle accept strobe from the receiver
//   i_frame_restart       - synchronous restart of the frame counters/state
//   o_window              - 3x3 window, row-major, bottom-right pixel in the LSBs
//   o_window_valid        - one-cycle strobe, window and centre coordinates valid
//   o_centre_x/_y         - coordinates of the window centre pixel
//   o_frame_done          - one-cycle pulse after the last pixel of a frame
//   o_busy                - high while a frame is being received
//   o_overrun             - sticky protocol-violation flag (PIXEL_OVERRUN_DETECT_EN only)
// Optional feature macro: PIXEL_OVERRUN_DETECT_EN
module pixel_window_builder
  import pixel_window_pkg::*;
#(
  parameter int unsigned ImageWidth  = DefaultImageWidth,
  parameter int unsigned ImageHeight = DefaultImageHeight,
  parameter int unsigned PixelBits   = DefaultPixelBits
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [PixelBits-1:0]           i_pixel_data,
  input  logic                           i_pixel_valid,
  input  logic                           i_frame_restart,
  output logic [9*PixelBits-1:0]         o_window,
  output logic                           o_window_valid,
  output logic [$clog2(ImageWidth)-1:0]  o_centre_x,
  output logic [$clog2(ImageHeight)-1:0] o_centre_y,
  output logic                           o_frame_done,
  output logic                           o_busy
`ifdef PIXEL_OVERRUN_DETECT_EN
  ,
  output logic                           o_overrun
`endif
);

  localparam int unsigned ColBits = $clog2(ImageWidth);
  localparam int unsigned RowBits = $clog2(ImageHeight);
  localparam logic [ColBits-1:0] LastCol = ColBits'(ImageWidth - 1);
  localparam logic [RowBits-1:0] LastRow = RowBits'(ImageHeight - 1);

  windowState_t r_state, w_state_d, w_state_eff;
  logic [ColBits-1:0] r_col, w_col_d, w_col_eff;
  logic [RowBits-1:0] r_row, w_row_d, w_row_eff;
  logic [PixelBits-1:0] r_win [3][3];  // [row][col], row 0 is the oldest image row
  logic [PixelBits-1:0] w_old_rd, w_new_rd;
  logic [ColBits-1:0] r_centre_x;
  logic [RowBits-1:0] r_centre_y;
  logic r_window_valid, r_frame_done;
  logic w_accept, w_last_col, w_emit, w_frame_done_d;

  // A restart makes this cycle behave as if the block were idle at (0,0), so a
  // coincident strobe is taken as the first pixel of the new frame.
  assign w_state_eff = i_frame_restart ? IDLE : r_state;
  assign w_col_eff   = i_frame_restart ? '0 : r_col;
  assign w_row_eff   = i_frame_restart ? '0 : r_row;
  assign w_accept    = i_pixel_valid && (w_state_eff != DONE);
  assign w_last_col  = (w_col_eff == LastCol);
  assign w_emit      = w_accept && (w_row_eff >= RowBits'(2)) && (w_col_eff >= ColBits'(2));

  always_comb begin
    w_state_d      = w_state_eff;
    w_col_d        = w_col_eff;
    w_row_d        = w_row_eff;
    w_frame_done_d = 1'b0;
    if (w_state_eff == DONE) begin
      w_state_d = IDLE;
    end else if (w_accept) begin
      w_col_d = w_last_col ? '0 : w_col_eff + ColBits'(1);
      w_row_d = w_last_col ? w_row_eff + RowBits'(1) : w_row_eff;
      unique case (w_state_eff)
        IDLE: w_state_d = FILL;
        FILL: begin
          if (w_last_col && (w_row_eff == RowBits'(1))) w_state_d = STREAM;
        end
        STREAM: begin
          if (w_last_col && (w_row_eff == LastRow)) begin
            w_state_d      = DONE;
            w_row_d        = '0;
            w_frame_done_d = 1'b1;
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_col          <= '0;
      r_row          <= '0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_centre_x     <= '0;
      r_centre_y     <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_state        <= w_state_d;
      r_col          <= w_col_d;
      r_row          <= w_row_d;
      r_window_valid <= w_emit;
      r_frame_done   <= w_frame_done_d;
      if (w_emit) begin
        r_centre_x <= w_col_eff - ColBits'(1);
        r_centre_y <= w_row_eff - RowBits'(1);
      end
      if (w_accept) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        // Line buffer reads return the pre-write contents of this column.
        r_win[0][2] <= w_old_rd;
        r_win[1][2] <= w_new_rd;
        r_win[2][2] <= i_pixel_data;
      end
    end
  end

  // Two rows back: gets the previous row's pixel as the newer row moves down.
  line_buffer #(
    .Depth (ImageWidth),
    .Width (PixelBits)
  ) u_line_buf_old (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_addr  (w_col_eff),
    .i_wdata (w_new_rd),
    .o_rdata (w_old_rd)
  );

  line_buffer #(
    .Depth (ImageWidth),
    .Width (PixelBits)
  ) u_line_buf_new (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_addr  (w_col_eff),
    .i_wdata (i_pixel_data),
    .o_rdata (w_new_rd)
  );

  assign o_window = {r_win[0][0], r_win[0][1], r_win[0][2],
                     r_win[1][0], r_win[1][1], r_win[1][2],
                     r_win[2][0], r_win[2][1], r_win[2][2]};
  assign o_window_valid = r_window_valid;
  assign o_centre_x     = r_centre_x;
  assign o_centre_y     = r_centre_y;
  assign o_frame_done   = r_frame_done;
  assign o_busy         = (r_state == FILL) || (r_state == STREAM);

`ifdef PIXEL_OVERRUN_DETECT_EN
  logic r_prev_valid, r_overrun;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prev_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_prev_valid <= i_pixel_valid;
      if (i_frame_restart) begin
        r_overrun <= 1'b0;
      end else if (i_pixel_valid && ((r_state == DONE) || r_prev_valid)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_pixel_window_builder.sv
module tb_pixel_window_builder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [PB-1:0] pixel_data;
  logic          pixel_valid;
  logic          frame_restart;
  logic [9*PB-1:0] window;
  logic          window_valid;
  logic [1:0]    centre_x;
  logic [1:0]    centre_y;
  logic          frame_done;
  logic          busy;
`ifdef PIXEL_OVERRUN_DETECT_EN
  logic          overrun;
`endif

  always #5 clk = ~clk;

  pixel_window_builder #(
    .ImageWidth  (W),
    .ImageHeight (H),
    .PixelBits   (PB)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_pixel_data    (pixel_data),
    .i_pixel_valid   (pixel_valid),
    .i_frame_restart (frame_restart),
    .o_window        (window),
    .o_window_valid  (window_valid),
    .o_centre_x      (centre_x),
    .o_centre_y      (centre_y),
    .o_frame_done    (frame_done),
    .o_busy          (busy)
`ifdef PIXEL_OVERRUN_DETECT_EN
    ,
    .o_overrun       (overrun)
`endif
  );

  typedef struct packed {
    logic [9*PB-1:0] win;
    logic [1:0]      cx;
    logic [1:0]      cy;
  } exp_t;

  exp_t            exp_q[$];
  logic [PB-1:0]   img [W*H];
  logic [9*PB-1:0] first_win;
  int              n_tests = 0;
  int              n_fail  = 0;
  int              n_windows;

  task automatic check(input string tag, input logic [9*PB-1:0] obs, input logic [9*PB-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference neighbourhood straight from the bench's copy of the image.
  function automatic logic [9*PB-1:0] exp_win(input int col, input int row);
    logic [9*PB-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w = {w[8*PB-1:0], img[(row - 2 + r) * W + (col - 2 + c)]};
      end
    end
    return w;
  endfunction

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_valid", (9*PB)'(window_valid), (9*PB)'(1'b0));
      check("idle_done", (9*PB)'(frame_done), (9*PB)'(1'b0));
    end
  endtask

  task automatic strobe(input int idx, input logic [PB-1:0] val, input logic restart);
    int   col;
    int   row;
    logic expv;
    exp_t e;
    col      = idx % W;
    row      = idx / W;
    img[idx] = val;
    @(negedge clk);
    pixel_data    = val;
    pixel_valid   = 1'b1;
    frame_restart = restart;
    expv = (row >= 2) && (col >= 2);
    if (expv) begin
      e.win = exp_win(col, row);
      e.cx  = 2'(col - 1);
      e.cy  = 2'(row - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    pixel_valid   = 1'b0;
    frame_restart = 1'b0;
    check("valid_latency", (9*PB)'(window_valid), (9*PB)'(expv));
    check("frame_done", (9*PB)'(frame_done), (9*PB)'(idx == W * H - 1));
    check("busy", (9*PB)'(busy), (9*PB)'(idx != W * H - 1));
    if (window_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("window", window, e.win);
      check("centre_x", (9*PB)'(centre_x), (9*PB)'(e.cx));
      check("centre_y", (9*PB)'(centre_y), (9*PB)'(e.cy));
      if (n_windows == 0) first_win = window;
      n_windows++;
    end
    idle_check(6);
  endtask

  task automatic send_frame(input int base, input int first_idx);
    for (int i = first_idx; i < W * H; i++) begin
      strobe(i, PB'(base + i), 1'b0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_window"}, window, '0);
    check({tag, "_valid"}, (9*PB)'(window_valid), (9*PB)'(1'b0));
    check({tag, "_cx"}, (9*PB)'(centre_x), (9*PB)'(2'd0));
    check({tag, "_cy"}, (9*PB)'(centre_y), (9*PB)'(2'd0));
    check({tag, "_done"}, (9*PB)'(frame_done), (9*PB)'(1'b0));
    check({tag, "_busy"}, (9*PB)'(busy), (9*PB)'(1'b0));
  endtask

  initial begin
    rst           = 1'b1;
    pixel_data    = '0;
    pixel_valid   = 1'b0;
    frame_restart = 1'b0;
    #2;
    check_outputs_zero("reset");
`ifdef PIXEL_OVERRUN_DETECT_EN
    check("reset_overrun", (9*PB)'(overrun), (9*PB)'(1'b0));
`endif
    @(negedge clk);
    rst = 1'b0;
    idle_check(2);

    // Frame A: pixels 0..15.
    n_windows = 0;
    send_frame(0, 0);
    check("frameA_count", (9*PB)'(n_windows), (9*PB)'(4));
    check("frameA_first", first_win,
          {12'd0, 12'd1, 12'd2, 12'd4, 12'd5, 12'd6, 12'd8, 12'd9, 12'd10});

    // Frame B back-to-back: pixels 100..115.
    n_windows = 0;
    send_frame(100, 0);
    check("frameB_count", (9*PB)'(n_windows), (9*PB)'(4));
    check("frameB_first", first_win,
          {12'd100, 12'd101, 12'd102, 12'd104, 12'd105, 12'd106, 12'd108, 12'd109, 12'd110});

    // Partial frame into STREAM, then restart together with pixel 0xABC.
    n_windows = 0;
    for (int i = 0; i < 10; i++) strobe(i, PB'(200 + i), 1'b0);
    strobe(0, 12'hABC, 1'b1);
    send_frame(300, 1);
    check("restart_count", (9*PB)'(n_windows), (9*PB)'(4));
    check("restart_first", first_win,
          {12'hABC, 12'd301, 12'd302, 12'd304, 12'd305, 12'd306, 12'd308, 12'd309, 12'd310});

    // Asynchronous reset between clock edges mid-STREAM.
    n_windows = 0;
    for (int i = 0; i < 11; i++) strobe(i, PB'(500 + i), 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_windows = 0;
    send_frame(600, 0);
    check("post_reset_count", (9*PB)'(n_windows), (9*PB)'(4));
    check("post_reset_first", first_win,
          {12'd600, 12'd601, 12'd602, 12'd604, 12'd605, 12'd606, 12'd608, 12'd609, 12'd610});

`ifdef PIXEL_OVERRUN_DETECT_EN
    check("overrun_clear", (9*PB)'(overrun), (9*PB)'(1'b0));
    @(negedge clk);
    pixel_data  = 12'd1;
    pixel_valid = 1'b1;
    @(negedge clk);
    pixel_data  = 12'd2;
    @(negedge clk);
    pixel_valid = 1'b0;
    check("overrun_set", (9*PB)'(overrun), (9*PB)'(1'b1));
    repeat (3) @(negedge clk);
    check("overrun_sticky", (9*PB)'(overrun), (9*PB)'(1'b1));
    frame_restart = 1'b1;
    @(negedge clk);
    frame_restart = 1'b0;
    check("overrun_restart", (9*PB)'(overrun), (9*PB)'(1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_window_builder.md
Name: pixel_window_builder

Overview:
- Downstream of the SPI pixel receiver. Consumes its 12-bit pixel strobe stream and holds the last two image rows in line buffers.
- Emits a 3x3 pixel neighbourhood with its centre coordinates, one per accepted pixel once the window is fully inside the image.
- Feeds the Sobel/edge kernel stage. Raster order, no backpressure: pixels arrive far slower than clk.

Parameters:
- imageWidth, 160, pixels per row (>=3)
- imageHeight, 120, rows per frame (>=3)
- pixelBits, 12, bits per pixel; must match the receiver's writeData width

Ports:
- clk  input  1  system clock; also clocks the upstream receiver, so no CDC in this block
- reset  input  1  asynchronous, active-high reset
- pixelData  input  pixelBits  pixel from receiver (writeData)
- pixelValid  input  1  one-cycle strobe; pixelData is accepted on every cycle it is high
- frameRestart  input  1  synchronous clear of counters/state; starts a new frame
- window  output  9*pixelBits  3x3 neighbourhood, packed row-major: [top-left ... bottom-right], bottom-right in LSBs
- windowValid  output  1  one-cycle strobe; window and centre coordinates valid
- centreX  output  $clog2(imageWidth)  column of window centre
- centreY  output  $clog2(imageHeight)  row of window centre
- frameDone  output  1  one-cycle pulse after last pixel of a frame is accepted
- busy  output  1  high in FILL or STREAM

Behaviour:
- Reset: state=IDLE; col=0, row=0; window regs=0; windowValid=0, frameDone=0, centreX=0, centreY=0. Line buffer contents are not reset; they are never read before being written in a frame.
- States:
  - IDLE: on pixelValid -> FILL.
  - FILL: rows 0-1. When a pixel is accepted at (col=W-1, row=1) -> STREAM.
  - STREAM: rows 2..H-1. Last pixel accepted at (W-1, H-1) -> DONE.
  - DONE: lasts one cycle; frameDone=1 -> IDLE.
  - A pixelValid seen in IDLE is itself accepted as pixel (0,0).
- Acceptance at (col,row):
  - lineBufOld[col] <= lineBufNew[col]
  - lineBufNew[col] <= pixelData
  - Window shifts one column left.
  - The new right column becomes {lineBufOld[col], lineBufNew[col], pixelData}, read before the write.
- col increments and wraps W-1 -> 0 with row+1. Row wraps only through DONE/IDLE.
- At col=0 the left two window columns hold the previous row's tail. This is acceptable because no window is emitted until col>=2.
- windowValid=1 in the cycle after acceptance iff accepted row>=2 and col>=2. Latency 1 clk.
  - centreX = col-1, centreY = row-1, registered with the window.
  - Windows per frame: (W-2)*(H-2).
- pixelValid while in DONE: pixel dropped, counters untouched.
- frameRestart: counters to 0, state to IDLE, windowValid/frameDone forced 0 that cycle. Window regs are not cleared.
  - frameRestart together with pixelValid: restart wins; the pixel is accepted as (0,0) of the new frame, state -> FILL.
- Reset mid-frame: immediate return to reset values; a partial frame is discarded.
- busy = (state==FILL || state==STREAM).

Optional Feature:
- Macro: PIXEL_OVERRUN_DETECT_EN
- With the macro defined:
  - Extra output overrun (1 bit), sticky.
  - Set when pixelValid arrives in DONE, or when pixelValid is high on two consecutive clks (receiver protocol violation).
  - Cleared by reset or frameRestart.
  - Pixel handling is unchanged.
- Without it: no overrun port and no detection logic.

Decomposition:
- Package pixel_window_pkg holds the state enum windowState_t {IDLE, FILL, STREAM, DONE} and the default image-size constants, shared with the edge kernel stage.
- One sub-module: line_buffer.
  - Parameters: depth=imageWidth, width=pixelBits.
  - Combinational read port and synchronous write port at the same address; no reset.
  - Instantiated twice.

Test Plan:
- W=4, H=4, pixels 0..15 in raster order, one strobe every 8 clks -> exactly 4 windowValid pulses.
  - Centres (1,1),(2,1),(1,2),(2,2).
  - First window = {0,1,2,4,5,6,8,9,10}.
  - frameDone one cycle after DONE entry.
- Same frame, check timing -> windowValid exactly 1 clk after the strobe for (2,2); nothing emitted for rows 0-1 or cols 0-1.
- Two back-to-back frames (values +100 in the second) -> second frame first window = {100,101,102,104,105,106,108,109,110}; no stale data from frame 1.
- frameRestart asserted together with a strobe mid-frame (pixel 0xABC) -> counters restart; 0xABC is treated as (0,0); the following frame emits the correct 4 windows.
- Async reset asserted mid-STREAM, between clk edges -> all outputs 0 immediately; subsequent full frame correct.
- With PIXEL_OVERRUN_DETECT_EN: strobe on two consecutive clks -> overrun=1 and stays 1; cleared by frameRestart. Without the macro the bench compiles without the port.
